// File: rtl/dmem_store_ctrl.sv
// Store path controller between the MEM stage and data memory: lane placement,
// alignment trap and a request/grant/done handshake.
//
// state  | meaning
// IDLE   | waiting for a store from the MEM stage
// REQ    | mem_req asserted, waiting for mem_gnt (flush may still cancel)
// WAIT   | granted, waiting for mem_done
module dmem_store_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [1:0]        st_oper,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              flush,
    output logic              stall,
    output logic              st_ades,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        offset;
    logic              reserved;
    logic              misaligned;
    logic              present;
    logic              accept;
    logic [DATA_W-1:0] wdata_nxt;
    logic [3:0]        be_nxt;

    assign offset = st_addr[1:0];

    always_comb begin
        reserved   = 1'b0;
        misaligned = 1'b0;
        wdata_nxt  = st_data;
        be_nxt     = 4'b1111;
        case (st_oper)
            2'b00: begin
                wdata_nxt = {4{st_data[7:0]}};
                be_nxt    = 4'b0001 << offset;
            end
            2'b01: begin
                misaligned = offset[0];
                wdata_nxt  = {2{st_data[15:0]}};
                be_nxt     = offset[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = (offset != 2'b00);
            end
            default: begin
                reserved = 1'b1;
            end
        endcase
    end

    // Gated by rst_n so stall and st_ades read 0 while reset is held.
    assign present = rst_n && (state == S_IDLE) && st_valid && !flush && !reserved;
    assign accept  = present && !misaligned;
    assign st_ades = present && misaligned;
    assign stall   = accept || (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= wdata_nxt;
                        mem_be    <= be_nxt;
                        mem_req   <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant beats a simultaneous flush; done with grant completes at once.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_done ? S_IDLE : S_WAIT;
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
